// File: rtl/mcu_pkg.sv
// Shared definitions for the MCU memory/convolution crossbar sequencer.
// Holds the crossbar state encodings, the PROC write-enable masks and the
// sequencer FSM state type.
package mcu_pkg;

    // Crossbar state select encodings.
    localparam logic [1:0] ST_LOAD = 2'b00;
    localparam logic [1:0] ST_PROC = 2'b01;
    localparam logic [1:0] ST_OUT  = 2'b10;
    localparam logic [1:0] ST_IDLE = 2'b11;

    // Write-back masks for the two PROC half-phases (results written in place).
    localparam logic [3:0] WE_SUB0 = 4'b0011;
    localparam logic [3:0] WE_SUB1 = 4'b1100;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StIssue,
        StWait,
        StWrite,
        StOut,
        StDone
    } seq_state_e;

endpackage

// File: rtl/mcu_row_counter.sv
// Wrap counter with clear, enable and a runtime limit.
// Ports:
//   clk_i    clock (rising edge)
//   rst_i    synchronous active-high reset
//   clr_i    force count to zero (wins over en_i)
//   en_i     advance; wraps to zero after reaching limit_i
//   limit_i  last value before wrap
//   count_o  current count
//   tc_o     count_o == limit_i
module mcu_row_counter #(
    parameter int unsigned Width = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [Width-1:0] limit_i,
    output logic [Width-1:0] count_o,
    output logic             tc_o
);

    logic [Width-1:0] count_q, count_d;

    assign tc_o    = (count_q == limit_i);
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = tc_o ? '0 : count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mcu_sequencer.sv
// Sequencer for the MCU memory/convolution crossbar: LOAD streams pixels into
// the N+2 column memories, PROC runs each row through the convolver in two
// half-phases with in-place write-back, OUT streams results out under
// valid/ready. Sole source of the crossbar selects.
// Ports:
//   i_clock, i_reset        clock, synchronous active-high reset
//   i_start, i_rows         job start (IDLE only) and rows per column
//   i_valid, o_ready        LOAD input handshake
//   o_state, o_substate     crossbar state / substate selects
//   o_memSelect, o_addr     crossbar memory select, column-memory address
//   o_we                    per-memory write enables
//   o_conv_valid            convolver input valid
//   o_out_valid, i_out_ready OUT handshake
//   o_busy, o_done          status
module mcu_sequencer
    import mcu_pkg::*;
#(
    parameter int unsigned N         = 2,
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned CONV_LAT  = 2
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_start,
    input  logic [ADDR_BITS-1:0]       i_rows,
    input  logic                       i_valid,
    output logic                       o_ready,
    output logic [1:0]                 o_state,
    output logic [$clog2(N/2+1):0]     o_substate,
    output logic [$clog2(N+2)-1:0]     o_memSelect,
    output logic [ADDR_BITS-1:0]       o_addr,
    output logic [N+1:0]               o_we,
    output logic                       o_conv_valid,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int unsigned LAT_W = $clog2(CONV_LAT + 1);
    localparam int unsigned SUB_W = $clog2(N / 2 + 1) + 1;
    localparam int unsigned SEL_W = $clog2(N + 2);
    localparam int unsigned WE_W  = N + 2;

    localparam logic [1:0]       MEM_LAST = 2'(N + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(CONV_LAT - 1);

    if (N != 2) begin : g_bad_n
        $error("mcu_sequencer: only N=2 is supported");
    end
    if (CONV_LAT < 1) begin : g_bad_lat
        $error("mcu_sequencer: CONV_LAT must be at least 1");
    end

    seq_state_e             state_q, state_d;
    logic [ADDR_BITS-1:0]   rows_q, rows_d;
    logic [1:0]             mem_q, mem_d;
    logic                   sub_q, sub_d;
    logic [LAT_W-1:0]       lat_q, lat_d;

    logic [ADDR_BITS-1:0]   row;
    logic                   row_tc, row_clr, row_en;

    mcu_row_counter #(
        .Width (ADDR_BITS)
    ) u_row_counter (
        .clk_i   (i_clock),
        .rst_i   (i_reset),
        .clr_i   (row_clr),
        .en_i    (row_en),
        .limit_i (rows_q - ADDR_BITS'(1)),
        .count_o (row),
        .tc_o    (row_tc)
    );

    always_comb begin
        state_d      = state_q;
        rows_d       = rows_q;
        mem_d        = mem_q;
        sub_d        = sub_q;
        lat_d        = lat_q;
        row_clr      = 1'b0;
        row_en       = 1'b0;
        o_state      = ST_IDLE;
        o_ready      = 1'b0;
        o_substate   = '0;
        o_memSelect  = '0;
        o_addr       = '0;
        o_we         = '0;
        o_conv_valid = 1'b0;
        o_out_valid  = 1'b0;
        o_busy       = 1'b1;
        o_done       = 1'b0;

        unique case (state_q)
            StIdle: begin
                o_busy = 1'b0;
                if (i_start) begin
                    rows_d  = i_rows;
                    row_clr = 1'b1;
                    mem_d   = '0;
                    sub_d   = 1'b0;
                    lat_d   = '0;
                    state_d = (i_rows == '0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                o_state     = ST_LOAD;
                o_ready     = 1'b1;
                o_memSelect = SEL_W'(mem_q);
                o_addr      = row;
                if (i_valid) begin
                    o_we   = WE_W'(1) << mem_q;
                    row_en = 1'b1;
                    // Row-major per memory: the row counter wraps on its own.
                    if (row_tc) begin
                        if (mem_q == MEM_LAST) begin
                            mem_d   = '0;
                            state_d = StIssue;
                        end else begin
                            mem_d = mem_q + 2'd1;
                        end
                    end
                end
            end
            StIssue: begin
                o_state      = ST_PROC;
                o_substate   = SUB_W'(sub_q);
                o_addr       = row;
                o_conv_valid = 1'b1;
                lat_d        = '0;
                state_d      = StWait;
            end
            StWait: begin
                o_state    = ST_PROC;
                o_substate = SUB_W'(sub_q);
                o_addr     = row;
                lat_d      = lat_q + LAT_W'(1);
                if (lat_q == LAT_LAST) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                o_state    = ST_PROC;
                o_substate = SUB_W'(sub_q);
                o_addr     = row;
                o_we       = sub_q ? WE_W'(WE_SUB1) : WE_W'(WE_SUB0);
                if (!sub_q) begin
                    sub_d   = 1'b1;
                    state_d = StIssue;
                end else if (!row_tc) begin
                    sub_d   = 1'b0;
                    row_en  = 1'b1;
                    state_d = StIssue;
                end else begin
                    sub_d   = 1'b0;
                    mem_d   = '0;
                    row_clr = 1'b1;
                    state_d = StOut;
                end
            end
            StOut: begin
                o_state     = ST_OUT;
                o_memSelect = SEL_W'(mem_q);
                o_addr      = row;
                o_out_valid = 1'b1;
                // Mem-major per row; selects hold while the sink stalls.
                if (i_out_ready) begin
                    if (mem_q == MEM_LAST) begin
                        mem_d  = '0;
                        row_en = 1'b1;
                        if (row_tc) begin
                            state_d = StDone;
                        end
                    end else begin
                        mem_d = mem_q + 2'd1;
                    end
                end
            end
            StDone: begin
                o_done  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= StIdle;
            rows_q  <= '0;
            mem_q   <= '0;
            sub_q   <= 1'b0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            rows_q  <= rows_d;
            mem_q   <= mem_d;
            sub_q   <= sub_d;
            lat_q   <= lat_d;
        end
    end

endmodule
